// File: rtl/mux16_scan_serializer_if.sv
// rtl/mux16_scan_serializer_if.sv - select/sample/stream bundle between the scan serializer and its user
interface mux16_scan_serializer_if;
  logic        start;
  logic        mux_y;
  logic [3:0]  sel;
  logic        busy;
  logic        bit_out;
  logic        bit_valid;
  logic [3:0]  bit_idx;
  logic [15:0] word_out;
  logic        word_valid;

  modport master (
    input  start, mux_y,
    output sel, busy, bit_out, bit_valid, bit_idx, word_out, word_valid
  );

  modport slave (
    output start, mux_y,
    input  sel, busy, bit_out, bit_valid, bit_idx, word_out, word_valid
  );
endinterface

// File: rtl/mux16_scan_serializer.sv
// rtl/mux16_scan_serializer.sv - walks a 16:1 mux select, samples y after a settle delay, streams bits and a word
// Optional: define MUX_SCAN_CONT_EN for back-to-back continuous scanning.
module mux16_scan_serializer #(
  parameter int unsigned SETTLE    = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic                      clk,
  input logic                      rst_n,
  mux16_scan_serializer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] FIRST_CH   = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] LAST_CH    = MSB_FIRST ? 4'd0  : 4'd15;
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  settle_q, settle_d;
  logic        busy_q, busy_d;
  logic        bit_out_q, bit_out_d;
  logic        bit_valid_q, bit_valid_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [15:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    settle_d     = settle_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    bit_idx_d    = bit_idx_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SCAN;
          sel_d    = FIRST_CH;
          settle_d = 4'd0;
        end
      end
      SCAN: begin
        if (settle_q != SETTLE_CNT) begin
          settle_d = settle_q + 4'd1;
        end else begin
          word_d[sel_q] = bus.mux_y;
          bit_out_d     = bus.mux_y;
          bit_idx_d     = sel_q;
          bit_valid_d   = 1'b1;
          // sel parks on the last channel so it never wraps within a scan
          if (sel_q == LAST_CH) begin
            state_d = DONE;
          end else begin
            sel_d    = MSB_FIRST ? sel_q - 4'd1 : sel_q + 4'd1;
            settle_d = 4'd0;
          end
        end
      end
      DONE: begin
        word_valid_d = 1'b1;
`ifdef MUX_SCAN_CONT_EN
        state_d  = SCAN;
        sel_d    = FIRST_CH;
        settle_d = 4'd0;
`else
        state_d  = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 4'd0;
      settle_q     <= 4'd0;
      busy_q       <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_idx_q    <= 4'd0;
      word_q       <= 16'h0000;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      settle_q     <= settle_d;
      busy_q       <= busy_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      bit_idx_q    <= bit_idx_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.word_out   = word_q;
  assign bus.word_valid = word_valid_q;

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// tb/tb_mux16_scan_serializer.sv - randomized self-checking bench against a timeline model of the scan
module tb_mux16_scan_serializer;

  typedef struct packed {
    logic [3:0]  sel;
    logic        busy;
    logic        bit_out;
    logic        bit_valid;
    logic [3:0]  bit_idx;
    logic [15:0] word_out;
    logic        word_valid;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_r [3];
  logic [15:0] pat [3];
  obs_t        obs [3];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mux16_scan_serializer_if ifc0 ();
  mux16_scan_serializer_if ifc1 ();
  mux16_scan_serializer_if ifc2 ();

  mux16_scan_serializer #(.SETTLE(1), .MSB_FIRST(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
  mux16_scan_serializer #(.SETTLE(0), .MSB_FIRST(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
  mux16_scan_serializer #(.SETTLE(3), .MSB_FIRST(1'b0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

  // Behavioural 16:1 mux: y is the pattern bit addressed by the current select
  assign ifc0.start = start_r[0];
  assign ifc1.start = start_r[1];
  assign ifc2.start = start_r[2];
  assign ifc0.mux_y = pat[0][ifc0.sel];
  assign ifc1.mux_y = pat[1][ifc1.sel];
  assign ifc2.mux_y = pat[2][ifc2.sel];

  assign obs[0] = {ifc0.sel, ifc0.busy, ifc0.bit_out, ifc0.bit_valid, ifc0.bit_idx, ifc0.word_out, ifc0.word_valid};
  assign obs[1] = {ifc1.sel, ifc1.busy, ifc1.bit_out, ifc1.bit_valid, ifc1.bit_idx, ifc1.word_out, ifc1.word_valid};
  assign obs[2] = {ifc2.sel, ifc2.busy, ifc2.bit_out, ifc2.bit_valid, ifc2.bit_idx, ifc2.word_out, ifc2.word_valid};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int d);
    obs_t o;
    o = obs[d];
    check_eq("rst_sel", o.sel, 0);
    check_eq("rst_busy", o.busy, 0);
    check_eq("rst_bit_out", o.bit_out, 0);
    check_eq("rst_bit_valid", o.bit_valid, 0);
    check_eq("rst_bit_idx", o.bit_idx, 0);
    check_eq("rst_word_out", o.word_out, 16'h0000);
    check_eq("rst_word_valid", o.word_valid, 0);
  endtask

  // Timeline model: bit k lands (k+1)*(S+1) edges after start, word one edge after the 16th bit
  task automatic run_scan(input int d, input int s, input bit msb, input logic [15:0] p,
                          input bit guard, input bit late7);
    int per, k, kb, chb, exp_sel;
    logic bv;
    logic [15:0] exp_word;
    obs_t o;
    per = s + 1;
    pat[d] = p;
    exp_word = p;
    if (late7) begin
      pat[d][7] = 1'b0;
      exp_word[7] = 1'b1;
    end
    start_r[d] = 1'b1;
    tick();
    start_r[d] = 1'b0;
    for (int c = 0; c <= 16 * per + 3; c++) begin
      if (c > 0) tick();
      o = obs[d];
      k = c / per;
      if (k > 15) k = 15;
      exp_sel = msb ? 15 - k : k;
      check_eq("sel", o.sel, exp_sel);
      check_eq("busy", o.busy, c <= 16 * per);
      bv = (c > 0) && (c % per == 0) && (c <= 16 * per);
      check_eq("bit_valid", o.bit_valid, bv);
      if (bv) begin
        kb = c / per - 1;
        chb = msb ? 15 - kb : kb;
        check_eq("bit_idx", o.bit_idx, chb);
        check_eq("bit_out", o.bit_out, exp_word[chb]);
      end
      check_eq("word_valid", o.word_valid, c == 16 * per + 1);
      if (c == 16 * per + 1 || c == 16 * per + 3) check_eq("word_out", o.word_out, exp_word);
      start_r[d] = guard && (c == 3 || c == 9);
      if (late7 && c == 7 * per + 2) pat[d][7] = 1'b1;
    end
  endtask

  task automatic reset_mid_scan();
    obs_t o;
    pat[0] = 16'($urandom);
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    o = obs[0];
    check_eq("pre_rst_bit_valid", o.bit_valid, 1);
    rst_n = 1'b0;
    tick();
    check_reset(0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      o = obs[0];
      check_eq("post_rst_busy", o.busy, 0);
      check_eq("post_rst_word_valid", o.word_valid, 0);
      check_eq("post_rst_word_out", o.word_out, 16'h0000);
    end
  endtask

`ifdef MUX_SCAN_CONT_EN
  task automatic cont_test();
    obs_t o;
    int nw, last;
    nw = 0;
    last = 0;
    pat[0] = 16'h1234;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      tick();
      o = obs[0];
      check_eq("cont_busy", o.busy, 1);
      if (o.word_valid) begin
        if (nw == 0) begin
          check_eq("cont_first_at", c, 33);
          check_eq("cont_word0", o.word_out, 16'h1234);
          pat[0] = 16'hFFFF;
        end else begin
          check_eq("cont_gap", c - last, 33);
          check_eq("cont_wordn", o.word_out, 16'hFFFF);
        end
        nw++;
        last = c;
      end
    end
    check_eq("cont_word_count", nw, 3);
    rst_n = 1'b0;
    tick();
    check_reset(0);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_r[d] = 1'b0;
      pat[d] = 16'h0000;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) check_reset(d);
    rst_n = 1'b1;
    tick();
`ifdef MUX_SCAN_CONT_EN
    cont_test();
`else
    run_scan(0, 1, 1'b0, 16'hA5C3, 1'b0, 1'b0);
    run_scan(1, 0, 1'b1, 16'h8001, 1'b0, 1'b0);
    run_scan(0, 1, 1'b0, 16'h5A3C, 1'b1, 1'b0);
    run_scan(2, 3, 1'b0, 16'h0F0F, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_scan(0, 1, 1'b0, 16'($urandom), 1'b0, 1'b0);
      run_scan(1, 0, 1'b1, 16'($urandom), 1'b0, 1'b0);
      run_scan(2, 3, 1'b0, 16'($urandom), 1'b0, 1'b0);
    end
    run_scan(0, 1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    reset_mid_scan();
    run_scan(0, 1, 1'b0, 16'($urandom), 1'b0, 1'b0);
    run_scan(1, 0, 1'b1, 16'($urandom), 1'b1, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16_scan_serializer.md
Name: mux16_scan_serializer

Overview:
- Sequential select generator and sampler for the 16:1 mux stage.
- Drives the 4-bit select lines (sel3..sel0) of the 16:1 mux through all 16 channels, waits a programmable settle time per channel, then samples the mux output.
- Emits each sampled bit as a serial stream and assembles the full 16-bit capture word.
- Sits beside the 16:1 mux: its select outputs feed the mux, and its sample input consumes the mux y_out.

Parameters:
- SETTLE, 1, idle cycles between a select change and the sample of mux_y (0..15); per-channel cost is SETTLE+1 cycles.
- MSB_FIRST, 0, scan order: 0 = channel 0 up to 15; 1 = channel 15 down to 0.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- mux_y  input  1  output of the 16:1 mux (y_out).
- sel  output  4  mux select; sel[3]..sel[0] map to sel3..sel0.
- busy  output  1  high in SCAN and DONE.
- bit_out  output  1  most recently sampled channel value.
- bit_valid  output  1  one-cycle pulse with each new bit_out.
- bit_idx  output  4  channel index of bit_out.
- word_out  output  16  captured word; bit k = channel k.
- word_valid  output  1  one-cycle pulse when word_out is complete.

Behaviour:
- Interface (already decided): one clock (clk); reset rst_n is synchronous and active-low. It is evaluated on the clk rising edge only.
- Reset values: state=IDLE, sel=0, settle_cnt=0, busy=0, bit_out=0, bit_valid=0, bit_idx=0, word_out=16'h0000, word_valid=0.
- Reset asserted mid-scan: scan aborts and all outputs return to reset values on the next edge. A partial word is discarded.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - sel holds its last value.
  - When start=1: sel <= 0 (MSB_FIRST=0) or 15 (MSB_FIRST=1), settle_cnt <= 0, go to SCAN.
- SCAN:
  - If settle_cnt != SETTLE: settle_cnt++.
  - If settle_cnt == SETTLE:
    - word_out[sel] <= mux_y, bit_out <= mux_y, bit_idx <= sel, bit_valid <= 1 for that one cycle.
    - If sel is the last channel (15 ascending, 0 descending): go to DONE.
    - Otherwise sel steps +1 (ascending) or -1 (descending) and settle_cnt <= 0.
- DONE: word_valid = 1 for exactly one cycle, then go to IDLE.
- Timing:
  - Start accepted at edge T0. First bit_valid occurs at edge T0+SETTLE+1.
  - Bits are spaced SETTLE+1 cycles apart; 16 bit_valid pulses total.
  - word_valid is high in the cycle after the 16th bit_valid.
  - With SETTLE=1: 32 SCAN cycles, and word_valid is high 33 cycles after start is accepted.
- sel is registered and stable for SETTLE+1 cycles per channel. It never glitches between channels.
- start while busy=1 is ignored; no queuing.
- word_out is not cleared at scan start. Bits are overwritten in place. word_out is only guaranteed coherent at word_valid and holds until the next scan overwrites it.
- No wrap-around: sel never steps past 15 or below 0 within a scan.
- SETTLE=0: one channel per cycle, and mux_y is sampled in the same cycle sel changes. The mux path must meet a single-cycle path.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined: continuous mode.
  - DONE returns directly to SCAN with sel reloaded to the first channel, without start.
  - word_valid still pulses once per completed word.
  - busy stays high until reset.
  - start is ignored except from IDLE after reset.
- Not defined: DONE always returns to IDLE, and each scan needs a new start pulse.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles mid-scan (after 5 bit_valid pulses) -> next edge has all outputs at reset values, word_out=16'h0000, state IDLE, no word_valid.
- Ascending scan: SETTLE=1, MSB_FIRST=0, mux model channels = 16'hA5C3, pulse start -> 16 bit_valid pulses every 2 cycles with bit_idx 0..15 and bit_out = bits of 16'hA5C3 LSB first. word_valid at cycle 33 with word_out=16'hA5C3.
- Descending scan: MSB_FIRST=1, SETTLE=0, pattern 16'h8001 -> bit_idx 15..0 on consecutive cycles; bit_out=1 only at idx 15 and idx 0; word_out=16'h8001 in cycle 17.
- Busy guard: pulse start again at cycles 4 and 10 of a scan -> no restart, sel sequence unchanged, exactly one word_valid.
- Settle check: SETTLE=3, change channel 7's mux input from 0 to 1 two cycles after sel becomes 7 -> sampled bit 7 = 1; sel is stable for 4 cycles per channel.
- MUX_SCAN_CONT_EN defined, pattern 16'h1234 then 16'hFFFF after the first word -> back-to-back scans, word_valid pulses 33 cycles apart (SETTLE=1), words 16'h1234 then 16'hFFFF.
